uart_tx_responder: RTL and testbench
====================================

UART_TX_RESPONDER -- requirements
Module: uart_tx_responder

Interface
REQ-001 The module SHALL have parameter DATA_WIDTH, default 32, as the bus data width.
REQ-002 The module SHALL have parameter ADDR_WIDTH, default 32, as the width of the decoded register offset.
REQ-003 The module SHALL have parameter FIFO_DEPTH, default 4, as the TX FIFO entry count (power of two, at least 2).
REQ-004 The module SHALL have parameter BAUD_DIV_RST, default 16'd434, as the reset value of BAUDDIV.
REQ-005 The module SHALL have port clk, input, 1 bit: single clock, rising edge.
REQ-006 The module SHALL have port reset, input, 1 bit: reset, synchronous and active-high.
REQ-007 The module SHALL have port WrtEn, input, 1 bit: gated write strobe (UART select AND CPU write).
REQ-008 The module SHALL have port ADDRIn, input, ADDR_WIDTH bits: register offset already rebased to 0.
REQ-009 The module SHALL have port DataIn, input, DATA_WIDTH bits: write data.
REQ-010 The module SHALL have port ReadData, output, DATA_WIDTH bits: combinational register read data.
REQ-011 The module SHALL have port Tx, output, 1 bit: serial line, registered, idle high.

Function
REQ-012 Register map (ADDRIn[3:0]) SHALL be: 0x0 TXDATA (write-only, reads 0); 0x4 STATUS; 0x8 BAUDDIV (bits [15:0], R/W); any other offset reads 0 and ignores writes.
REQ-013 STATUS SHALL read {28'b0, overflow, fifo_empty, fifo_full, tx_busy} at bits [3:0].
REQ-014 Registers SHALL be written only on a rising edge with WrtEn=1; ReadData SHALL depend only on ADDRIn and current state, with no read side effects.
REQ-015 A TXDATA write SHALL push DataIn[7:0] into the FIFO when count<FIFO_DEPTH, or when full with a pop in the same cycle.
REQ-016 A TXDATA write to a full FIFO with no same-cycle pop SHALL be dropped and SHALL set sticky overflow.
REQ-017 Any write to offset 0x4 SHALL clear overflow; if the clear coincides with a new overflow, set SHALL win.
REQ-018 A BAUDDIV write of 0 SHALL store 1; the divider SHALL be sampled when a frame leaves IDLE, so mid-frame writes affect only the next frame.
REQ-019 The FSM states SHALL be IDLE, START, DATA, STOP; tx_busy = (state != IDLE).
REQ-020 In IDLE with the FIFO non-empty, the next edge SHALL pop the head into an 8-bit shift register, load the bit counter with 0, enter START, and drive Tx=0.
REQ-021 Each state SHALL hold Tx for exactly BAUDDIV clocks, timed by a 16-bit down-counter.
REQ-022 START SHALL go to DATA; DATA SHALL emit 8 bits LSB first then go to STOP; STOP SHALL drive Tx=1.
REQ-023 After STOP, the FSM SHALL enter START directly (back-to-back, no idle gap) if the FIFO is non-empty, else IDLE.
REQ-024 Frame length SHALL be exactly 10*BAUDDIV clocks; the latency from a TXDATA write edge into an empty idle block to Tx falling SHALL be 1 clock.
REQ-025 FIFO pointers SHALL wrap modulo FIFO_DEPTH; count range is 0..FIFO_DEPTH; fifo_full = (count==FIFO_DEPTH), fifo_empty = (count==0).

Reset
REQ-026 On a reset edge, the module SHALL set state=IDLE, Tx=1, FIFO count and pointers to 0, overflow=0, BAUDDIV=BAUD_DIV_RST, and the counters to 0.
REQ-027 Reset asserted mid-frame SHALL abort the frame, force Tx=1 at the same edge, and discard FIFO contents.
REQ-028 Reset SHALL take priority over a simultaneous write.

Verification
REQ-029 Scenario: reset, BAUDDIV:=4, TXDATA:=0xA5 -> Tx low 1 clock after the write for 4 clocks, then bits 1,0,1,0,0,1,0,1 (4 clocks each), then high 4 clocks; STATUS=0x4 afterward.
REQ-030 Scenario: BAUDDIV:=2, write 0x01, 0x02, 0x03 on consecutive cycles -> three contiguous 20-clock frames with no idle gap; tx_busy stays 1 for 60 clocks.
REQ-031 Scenario: FIFO_DEPTH=4, BAUDDIV=100, six writes in consecutive cycles -> first byte popped, next four fill the FIFO, the sixth is dropped; STATUS reads 0xB; a write to 0x4 returns STATUS to 0x3.
REQ-032 Scenario: write BAUDDIV:=0 -> BAUDDIV reads 1; a frame of 0xFF lasts 10 clocks.
REQ-033 Scenario: assert reset during DATA bit 3 of a frame -> Tx=1 at that edge; STATUS=0x4; BAUDDIV=434.
REQ-034 Scenario: full FIFO with a pop and a TXDATA write on the same edge -> write accepted, count stays 4, overflow stays 0.

Source files
------------

// File: rtl/uart_tx_responder.sv
// Memory-mapped UART transmitter: small TX FIFO, programmable baud divider,
// 8N1 framing with back-to-back frames when the FIFO still holds data.
module uart_tx_responder #(
  parameter int          DATA_WIDTH   = 32,
  parameter int          ADDR_WIDTH   = 32,
  parameter int          FIFO_DEPTH   = 4,
  parameter logic [15:0] BAUD_DIV_RST = 16'd434
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  WrtEn,
  input  logic [ADDR_WIDTH-1:0] ADDRIn,
  input  logic [DATA_WIDTH-1:0] DataIn,
  output logic [DATA_WIDTH-1:0] ReadData,
  output logic                  Tx
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_e;

  state_e          state_q, state_d;
  logic [15:0]     baud_q, baud_d, div_q, div_d, cnt_q, cnt_d;
  logic [7:0]      shift_q, shift_d;
  logic [2:0]      bit_q, bit_d;
  logic            tx_q, tx_d, ovf_q, ovf_d;
  logic [PW-1:0]   wptr_q, rptr_q;
  logic [CW-1:0]   count_q;
  logic [7:0]      mem_q [FIFO_DEPTH];

  logic wr_tx, wr_st, wr_baud, fifo_full, fifo_empty, tx_busy;
  logic pop, push, launch;
  logic unused_bits;

  assign unused_bits = ^{ADDRIn[ADDR_WIDTH-1:4], DataIn[DATA_WIDTH-1:16]};

  assign wr_tx      = WrtEn && (ADDRIn[3:0] == 4'h0);
  assign wr_st      = WrtEn && (ADDRIn[3:0] == 4'h4);
  assign wr_baud    = WrtEn && (ADDRIn[3:0] == 4'h8);
  assign fifo_full  = (count_q == CW'(FIFO_DEPTH));
  assign fifo_empty = (count_q == '0);
  assign tx_busy    = (state_q != IDLE);
  assign Tx         = tx_q;

  // A full FIFO still accepts a byte on the edge that pops its head.
  assign push  = wr_tx && (!fifo_full || pop);
  assign ovf_d = (wr_tx && fifo_full && !pop) || (ovf_q && !wr_st);
  assign baud_d = wr_baud ? ((DataIn[15:0] == 16'd0) ? 16'd1 : DataIn[15:0]) : baud_q;

  always_comb begin
    state_d = state_q;
    div_d   = div_q;
    cnt_d   = cnt_q;
    shift_d = shift_q;
    bit_d   = bit_q;
    tx_d    = tx_q;
    launch  = 1'b0;
    case (state_q)
      IDLE:  launch = !fifo_empty;
      START: begin
        if (cnt_q == 16'd0) begin
          state_d = DATA;
          cnt_d   = div_q - 16'd1;
          tx_d    = shift_q[0];
        end else cnt_d = cnt_q - 16'd1;
      end
      DATA: begin
        if (cnt_q == 16'd0) begin
          cnt_d = div_q - 16'd1;
          if (bit_q == 3'd7) begin
            state_d = STOP;
            tx_d    = 1'b1;
          end else begin
            bit_d   = bit_q + 3'd1;
            shift_d = shift_q >> 1;
            tx_d    = shift_q[1];
          end
        end else cnt_d = cnt_q - 16'd1;
      end
      STOP: begin
        if (cnt_q == 16'd0) begin
          if (!fifo_empty) launch = 1'b1;
          else             state_d = IDLE;
        end else cnt_d = cnt_q - 16'd1;
      end
      default: state_d = IDLE;
    endcase
    // Divider is latched per frame so BAUDDIV writes never disturb a frame in flight.
    if (launch) begin
      state_d = START;
      shift_d = mem_q[rptr_q];
      bit_d   = 3'd0;
      div_d   = baud_q;
      cnt_d   = baud_q - 16'd1;
      tx_d    = 1'b0;
    end
  end

  assign pop = launch;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      baud_q  <= BAUD_DIV_RST;
      div_q   <= 16'd0;
      cnt_q   <= 16'd0;
      shift_q <= 8'd0;
      bit_q   <= 3'd0;
      tx_q    <= 1'b1;
      ovf_q   <= 1'b0;
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      baud_q  <= baud_d;
      div_q   <= div_d;
      cnt_q   <= cnt_d;
      shift_q <= shift_d;
      bit_q   <= bit_d;
      tx_q    <= tx_d;
      ovf_q   <= ovf_d;
      if (push) wptr_q <= wptr_q + PW'(1);
      if (pop)  rptr_q <= rptr_q + PW'(1);
      count_q <= count_q + CW'(push) - CW'(pop);
    end
  end

  always_ff @(posedge clk) begin
    if (!reset && push) mem_q[wptr_q] <= DataIn[7:0];
  end

  always_comb begin
    ReadData = '0;
    case (ADDRIn[3:0])
      4'h4:    ReadData[3:0]  = {ovf_q, fifo_empty, fifo_full, tx_busy};
      4'h8:    ReadData[15:0] = baud_q;
      default: ReadData = '0;
    endcase
  end

endmodule

// File: tb/tb_uart_tx_responder.sv
// Directed bench for uart_tx_responder: expected per-clock Tx/busy levels are
// queued when bytes are written and popped as each clock edge is observed.
module tb_uart_tx_responder;

  logic        clk = 1'b0;
  logic        reset, WrtEn;
  logic [31:0] ADDRIn, DataIn, ReadData;
  logic        Tx;

  typedef struct packed { logic tx; logic busy; } exp_t;
  exp_t exp_q[$];
  int   tests = 0;
  int   fails = 0;

  uart_tx_responder dut (
    .clk(clk), .reset(reset), .WrtEn(WrtEn), .ADDRIn(ADDRIn),
    .DataIn(DataIn), .ReadData(ReadData), .Tx(Tx)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    exp_t e;
    @(posedge clk);
    #1;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      check("tx_line", {31'b0, Tx}, {31'b0, e.tx});
      if (ADDRIn[3:0] == 4'h4) check("tx_busy", {31'b0, ReadData[0]}, {31'b0, e.busy});
    end
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] d);
    ADDRIn = a; DataIn = d; WrtEn = 1'b1;
    step();
    WrtEn = 1'b0; ADDRIn = 32'h4;
  endtask

  task automatic rd(input string tag, input logic [31:0] a, input logic [31:0] exp);
    ADDRIn = a;
    #1;
    check(tag, ReadData, exp);
    ADDRIn = 32'h4;
  endtask

  task automatic push_idle(input int n);
    exp_t e;
    e.tx = 1'b1; e.busy = 1'b0;
    repeat (n) exp_q.push_back(e);
  endtask

  task automatic push_frame(input logic [7:0] d, input int div);
    exp_t e;
    e.busy = 1'b1;
    for (int i = 0; i < 10; i++) begin
      e.tx = (i == 0) ? 1'b0 : (i == 9) ? 1'b1 : d[i-1];
      repeat (div) exp_q.push_back(e);
    end
  endtask

  task automatic drain();
    while (exp_q.size() > 0) step();
  endtask

  initial begin
    reset = 1'b1; WrtEn = 1'b0; ADDRIn = 32'h4; DataIn = 32'h0;
    step(); step();
    reset = 1'b0;

    // reset state
    check("reset_tx", {31'b0, Tx}, 32'h1);
    rd("reset_status", 32'h4, 32'h4);
    rd("reset_baud", 32'h8, 32'd434);
    rd("txdata_reads0", 32'h0, 32'h0);
    rd("offC_reads0", 32'hC, 32'h0);

    // single 0xA5 frame, divider 4
    wr(32'h8, 32'd4);
    rd("baud4", 32'h8, 32'd4);
    push_idle(1); push_frame(8'hA5, 4); push_idle(1);
    wr(32'h0, 32'hA5);
    drain();
    rd("status_after_a5", 32'h4, 32'h4);

    // three back-to-back frames, divider 2
    wr(32'h8, 32'd2);
    push_idle(1);
    push_frame(8'h01, 2); push_frame(8'h02, 2); push_frame(8'h03, 2);
    push_idle(2);
    wr(32'h0, 32'h01); wr(32'h0, 32'h02); wr(32'h0, 32'h03);
    drain();

    // overflow: six writes into depth-4 FIFO, sixth dropped
    wr(32'h8, 32'd100);
    push_idle(1);
    for (int i = 1; i <= 5; i++) push_frame(8'(i * 17), 100);
    push_idle(1);
    for (int i = 1; i <= 6; i++) wr(32'h0, 32'(i * 17));
    rd("status_ovf", 32'h4, 32'hB);
    wr(32'h4, 32'h0);
    rd("status_ovf_clr", 32'h4, 32'h3);
    drain();
    rd("status_after_ovf", 32'h4, 32'h4);

    // full FIFO, write lands on the pop edge
    wr(32'h8, 32'd3);
    push_idle(1);
    push_frame(8'h31, 3); push_frame(8'h32, 3); push_frame(8'h33, 3);
    push_frame(8'h34, 3); push_frame(8'h35, 3); push_frame(8'h36, 3);
    push_idle(1);
    for (int i = 1; i <= 5; i++) wr(32'h0, 32'h30 + 32'(i));
    rd("status_full", 32'h4, 32'h3);
    repeat (26) step();
    wr(32'h0, 32'h36);
    rd("status_pop_push", 32'h4, 32'h3);
    drain();
    rd("status_after_full", 32'h4, 32'h4);

    // BAUDDIV 0 maps to 1
    wr(32'h8, 32'd0);
    rd("baud0_is1", 32'h8, 32'd1);
    push_idle(1); push_frame(8'hFF, 1); push_idle(1);
    wr(32'h0, 32'hFF);
    drain();

    // reset during DATA bit 3, with a simultaneous BAUDDIV write
    wr(32'h8, 32'd4);
    wr(32'h0, 32'h52); wr(32'h0, 32'h11); wr(32'h0, 32'h22);
    repeat (15) step();
    check("bit3_low", {31'b0, Tx}, 32'h0);
    rd("status_midframe", 32'h4, 32'h1);
    reset = 1'b1; WrtEn = 1'b1; ADDRIn = 32'h8; DataIn = 32'd7;
    step();
    check("reset_abort_tx", {31'b0, Tx}, 32'h1);
    WrtEn = 1'b0; reset = 1'b0;
    rd("status_after_rst", 32'h4, 32'h4);
    rd("baud_after_rst", 32'h8, 32'd434);
    push_idle(20);
    drain();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
